// File: rtl/vigenere_deciph_stream.sv
// vigenere_deciph_stream: streaming vigenere decryption with programmable key table and framing
module vigenere_deciph_stream #(
  parameter int KEY_DEPTH = 16,
  parameter int DCNT_W = 8,
  localparam int AW = $clog2(KEY_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr,
  input  logic [AW-1:0]     key_waddr,
  input  logic [7:0]        key_wdata,
  input  logic [AW:0]       key_len,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [7:0]        ct_data,
  input  logic              ct_sof,
  input  logic              ct_eof,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [7:0]        pt_data,
  output logic              pt_sof,
  output logic              pt_eof,
  output logic              cfg_err,
  output logic [DCNT_W-1:0] drop_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [4:0] key_mem [KEY_DEPTH];
  logic [AW-1:0] idx, cur_idx, nxt_idx;
  logic [AW:0] len_q, lat_len, cur_len;
  logic acc, proc, drop, is_lo, is_up, is_let;
  logic [4:0] k;
  logic [7:0] base, plain;
  logic [5:0] off, sum, d;
  always_comb begin
    ct_ready = !pt_valid || pt_ready;
    acc = ct_valid && ct_ready;
    proc = acc && (state == RUN || ct_sof);
    drop = acc && !proc;
    lat_len = (key_len == '0) ? (AW+1)'(1) : (key_len > (AW+1)'(KEY_DEPTH)) ? (AW+1)'(KEY_DEPTH) : key_len;
    cur_len = ct_sof ? lat_len : len_q;
    cur_idx = ct_sof ? '0 : idx;
    k = key_mem[cur_idx];
    is_lo = ct_data >= 8'h61 && ct_data <= 8'h7a;
    is_up = ct_data >= 8'h41 && ct_data <= 8'h5a;
    is_let = is_lo || is_up;
    base = is_lo ? 8'h61 : 8'h41;
    off = 6'(ct_data - base);
    sum = off + 6'd26 - {1'b0, k};
    d = (sum >= 6'd26) ? sum - 6'd26 : sum;
    plain = base + {2'b0, d};
    nxt_idx = !is_let ? cur_idx : ({1'b0, cur_idx} == cur_len - (AW+1)'(1)) ? '0 : cur_idx + AW'(1);
    state_n = proc ? (ct_eof ? IDLE : RUN) : state;
  end
  always_ff @(posedge clk)
    if (key_wr && state == IDLE) key_mem[key_waddr] <= 5'(key_wdata - 8'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      len_q <= (AW+1)'(1);
      pt_valid <= 1'b0;
      pt_data <= '0;
      pt_sof <= 1'b0;
      pt_eof <= 1'b0;
      cfg_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (proc) begin
        len_q <= cur_len;
        idx <= ct_eof ? '0 : nxt_idx;
        pt_valid <= 1'b1;
        pt_data <= is_let ? plain : ct_data;
        pt_sof <= ct_sof;
        pt_eof <= ct_eof;
      end else if (pt_ready) begin
        pt_valid <= 1'b0;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DCNT_W'(1);
      if (key_wr && state == RUN) cfg_err <= 1'b1;
    end
  end
endmodule

// File: doc/vigenere_deciph_stream.md
Name: vigenere_deciph_stream

Overview:
Streaming Vigenere decryption stage that sits directly downstream of the cipher stage. It consumes ciphertext bytes over a valid/ready interface and emits recovered plaintext bytes over a second valid/ready interface, with framing preserved. The key is held in a programmable key table loaded between frames. Letter case is preserved, and non-letters pass through unchanged without consuming key position.

Parameters:
KEY_DEPTH, 16, number of key table entries; must be a power of 2; sets the key_waddr width to log2(KEY_DEPTH).
DCNT_W, 8, width of the dropped-beat counter.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
key_wr  in  1  key table write strobe.
key_waddr  in  log2(KEY_DEPTH)  key table write address.
key_wdata  in  8  key character, 'a'-'z' or 'A'-'Z'.
key_len  in  log2(KEY_DEPTH)+1  active key length; sampled on the sof beat.
ct_valid  in  1  ciphertext beat valid.
ct_ready  out  1  stage can accept a beat.
ct_data  in  8  ciphertext byte.
ct_sof  in  1  first beat of frame.
ct_eof  in  1  last beat of frame; sof and eof may both be set on a 1-byte frame.
pt_valid  out  1  plaintext beat valid.
pt_ready  in  1  downstream accepts.
pt_data  out  8  plaintext byte.
pt_sof  out  1  sof, forwarded with the byte.
pt_eof  out  1  eof, forwarded with the byte.
cfg_err  out  1  sticky: a key write was attempted during a frame.
drop_cnt  out  DCNT_W  count of beats discarded outside a frame; saturates.

Behaviour:
- Reset values: pt_valid=0, pt_data=0, pt_sof=0, pt_eof=0, cfg_err=0, drop_cnt=0, state=IDLE, key index=0, latched length=1. The key table is not reset.
- Beat accept: ct_valid && ct_ready. Output transfer: pt_valid && pt_ready.
- Output register: single stage. ct_ready = !pt_valid || pt_ready (combinational). Latency from accepted beat to pt_valid is exactly 1 cycle. Full throughput of 1 beat/cycle with pt_ready held high.
- pt_data, pt_sof and pt_eof hold stable while pt_valid && !pt_ready.
- Key write:
  - Stored value = key_wdata[4:0]-1, i.e. a shift of 0-25 for 'a'/'A'..'z'/'Z'.
  - Writes take effect only in IDLE.
  - In RUN, writes are ignored and cfg_err is set; it is cleared only by rst.
- State machine:
  - IDLE: an accepted beat with ct_sof=1 is processed. It latches key_len (0 is treated as 1; values above KEY_DEPTH are clamped to KEY_DEPTH) and uses key index 0. Go to RUN unless ct_eof=1 on the same beat, in which case stay in IDLE.
  - IDLE: an accepted beat with ct_sof=0 is discarded (no output) and drop_cnt increments, saturating.
  - RUN: every accepted beat is processed. An accepted beat with ct_eof=1 returns to IDLE and resets the key index to 0.
  - RUN: an accepted beat with ct_sof=1 restarts the frame: it relatches key_len, resets the index to 0 and uses index 0 for this byte.
- Decrypt:
  - For 'a'-'z': p = 'a' + ((c-'a') - k + 26) mod 26.
  - For 'A'-'Z': the same with 'A'.
  - k is the key table entry at the current index.
  - Letters advance the index; it wraps from len-1 to 0.
  - Other bytes pass through unchanged and do not advance the index.
  - Arithmetic is at least 6 bits wide with no intermediate negatives; the mod is a single conditional subtract/add.
- Reset mid-frame: the frame is abandoned, pending output is cleared and the state returns to IDLE.
- When ct_valid=0 the index and state hold.

Test Plan:
- Key "key" written at addr 0-2, key_len=3. Frame "rijvs" (sof on 'r', eof on 's') -> pt "hello", one byte per cycle, pt_sof on 'h', pt_eof on 'o'.
- Key "key". Frame "ri jvs!" -> "he llo!"; the space and '!' pass through and the key stays aligned.
- Key "b" (len=1). Frame "aZ" -> "zY", checking wrap-around below 'a' and uppercase.
- Same "rijvs" frame with pt_ready toggling 1,0,0,1,... -> ct_ready low whenever pt_valid && !pt_ready; output still "hello" with no duplicated or lost bytes.
- In IDLE, 3 beats without sof -> no pt_valid, drop_cnt=3. Then key_wr mid-frame -> cfg_err=1, and decryption uses the old key.
- rst pulsed after 2 bytes of a frame -> pt_valid=0 next cycle. A new sof frame "rijvs" then decodes to "hello" from key index 0.
